// File: rtl/fe_mem_bridge_if.sv
// Signal bundle between the FE driver, the bridge and target memory.
// The bridge takes the slave view; the driver/memory environment takes the master view.
interface fe_mem_bridge_if #(
    parameter int ADDR_W = 11,
    parameter int LANES  = 8,
    parameter int DATA_W = 16
);
    localparam int LW = $clog2(LANES);

    logic                      fe_valid;
    logic                      fe_rst_in;
    logic [LANES-1:0]          fe_we;
    logic [ADDR_W-1:0]         fe_addr;
    logic [LANES*DATA_W-1:0]   fe_data;
    logic                      fe_busy;
    logic                      fe_rep_valid;
    logic [LANES*DATA_W-1:0]   fe_rep_data;
    logic                      tgt_rst;
    logic                      mem_valid;
    logic                      mem_ready;
    logic                      mem_we;
    logic [ADDR_W+LW-1:0]      mem_addr;
    logic [DATA_W-1:0]         mem_wdata;
    logic                      mem_rvalid;
    logic [DATA_W-1:0]         mem_rdata;

    modport slave (
        input  fe_valid, fe_rst_in, fe_we, fe_addr, fe_data,
        input  mem_ready, mem_rvalid, mem_rdata,
        output fe_busy, fe_rep_valid, fe_rep_data, tgt_rst,
        output mem_valid, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output fe_valid, fe_rst_in, fe_we, fe_addr, fe_data,
        output mem_ready, mem_rvalid, mem_rdata,
        input  fe_busy, fe_rep_valid, fe_rep_data, tgt_rst,
        input  mem_valid, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/fe_mem_bridge.sv
// Executes an 8-lane FE request lane by lane on a one-lane valid/ready memory port,
// gathers read data into a lane-ordered reply, and turns FE reset commands into a timed pulse.
module fe_mem_bridge #(
    parameter int ADDR_W     = 11,
    parameter int LANES      = 8,
    parameter int DATA_W     = 16,
    parameter int RST_CYCLES = 4
) (
    input  logic           clk,
    input  logic           rstn,
    fe_mem_bridge_if.slave bus
);
    localparam int LW = $clog2(LANES);
    localparam int CW = $clog2(RST_CYCLES + 1);
    localparam logic [LW-1:0] LAST_LANE = LW'(LANES - 1);
    localparam logic [CW-1:0] RST_LOAD  = CW'(RST_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, TRST, ISSUE, RWAIT, DONE} state_t;

    state_t                  state_reg;
    logic [LW-1:0]           lane_reg;
    logic [CW-1:0]           rst_cnt_reg;
    logic [LANES-1:0]        we_reg;
    logic [ADDR_W-1:0]       addr_reg;
    logic [LANES*DATA_W-1:0] data_reg;
    logic [LANES*DATA_W-1:0] shadow_reg;
    logic [LANES*DATA_W-1:0] rep_data_reg;
    logic                    busy_reg;
    logic                    rep_valid_reg;
    logic                    tgt_rst_reg;
    logic                    mem_valid_reg;
    logic                    mem_we_reg;
    logic [ADDR_W+LW-1:0]    mem_addr_reg;
    logic [DATA_W-1:0]       mem_wdata_reg;

    logic [DATA_W-1:0]       data_lane [LANES];
    logic [LANES*DATA_W-1:0] shadow_next;
    logic [DATA_W-1:0]       lane_value;
    logic [LW-1:0]           lane_inc;
    logic                    last_lane;
    logic                    accept;

    // Writes echo their own data into the reply; reads store what memory returned.
    assign lane_value = (state_reg == ISSUE) ? data_lane[lane_reg] : bus.mem_rdata;
    assign lane_inc   = lane_reg + LW'(1);
    assign last_lane  = (lane_reg == LAST_LANE);
    assign accept     = mem_valid_reg && bus.mem_ready;

    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            assign data_lane[gi] = data_reg[gi*DATA_W +: DATA_W];
            assign shadow_next[gi*DATA_W +: DATA_W] =
                (lane_reg == LW'(gi)) ? lane_value : shadow_reg[gi*DATA_W +: DATA_W];
        end
    endgenerate

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_reg     <= IDLE;
            lane_reg      <= '0;
            rst_cnt_reg   <= '0;
            we_reg        <= '0;
            addr_reg      <= '0;
            data_reg      <= '0;
            shadow_reg    <= '0;
            rep_data_reg  <= '0;
            busy_reg      <= 1'b0;
            rep_valid_reg <= 1'b0;
            tgt_rst_reg   <= 1'b0;
            mem_valid_reg <= 1'b0;
            mem_we_reg    <= 1'b0;
            mem_addr_reg  <= '0;
            mem_wdata_reg <= '0;
        end else begin
            rep_valid_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (bus.fe_valid) begin
                        busy_reg <= 1'b1;
                        lane_reg <= '0;
                        addr_reg <= bus.fe_addr;
                        if (bus.fe_rst_in) begin
                            state_reg   <= TRST;
                            tgt_rst_reg <= 1'b1;
                            rst_cnt_reg <= RST_LOAD;
                        end else begin
                            state_reg     <= ISSUE;
                            we_reg        <= bus.fe_we;
                            data_reg      <= bus.fe_data;
                            mem_valid_reg <= 1'b1;
                            mem_we_reg    <= bus.fe_we[0];
                            mem_addr_reg  <= {bus.fe_addr, {LW{1'b0}}};
                            mem_wdata_reg <= bus.fe_data[DATA_W-1:0];
                        end
                    end
                end
                TRST: begin
                    if (rst_cnt_reg == '0) begin
                        tgt_rst_reg   <= 1'b0;
                        state_reg     <= DONE;
                        rep_valid_reg <= 1'b1;
                    end else begin
                        rst_cnt_reg <= rst_cnt_reg - CW'(1);
                    end
                end
                ISSUE: begin
                    if (accept) begin
                        if (mem_we_reg) begin
                            shadow_reg <= shadow_next;
                            if (last_lane) begin
                                mem_valid_reg <= 1'b0;
                                state_reg     <= DONE;
                                rep_valid_reg <= 1'b1;
                                rep_data_reg  <= shadow_next;
                            end else begin
                                lane_reg      <= lane_inc;
                                mem_we_reg    <= we_reg[lane_inc];
                                mem_addr_reg  <= {addr_reg, lane_inc};
                                mem_wdata_reg <= data_lane[lane_inc];
                            end
                        end else begin
                            mem_valid_reg <= 1'b0;
                            state_reg     <= RWAIT;
                        end
                    end
                end
                RWAIT: begin
                    if (bus.mem_rvalid) begin
                        shadow_reg <= shadow_next;
                        if (last_lane) begin
                            state_reg     <= DONE;
                            rep_valid_reg <= 1'b1;
                            rep_data_reg  <= shadow_next;
                        end else begin
                            lane_reg      <= lane_inc;
                            state_reg     <= ISSUE;
                            mem_valid_reg <= 1'b1;
                            mem_we_reg    <= we_reg[lane_inc];
                            mem_addr_reg  <= {addr_reg, lane_inc};
                            mem_wdata_reg <= data_lane[lane_inc];
                        end
                    end
                end
                DONE: begin
                    busy_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign bus.fe_busy      = busy_reg;
    assign bus.fe_rep_valid = rep_valid_reg;
    assign bus.fe_rep_data  = rep_data_reg;
    assign bus.tgt_rst      = tgt_rst_reg;
    assign bus.mem_valid    = mem_valid_reg;
    assign bus.mem_we       = mem_we_reg;
    assign bus.mem_addr     = mem_addr_reg;
    assign bus.mem_wdata    = mem_wdata_reg;
endmodule
